seq_divider: RTL

Parametrised multi-cycle unsigned restoring divider, successor to the fixed 8/4-bit combinational divider.
- Computes quotient and remainder of a NUM_W-bit numerator by a DEN_W-bit denominator, one quotient bit per clock.
- Uses a start/busy/done handshake and flags divide-by-zero.
- Sits in datapaths that can tolerate NUM_W-cycle latency in exchange for a small area footprint.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 107 ++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
`timescale 1ns/1ps
package divider_pkg;

   localparam int unsigned NUM_W_DEF = 8;
   localparam int unsigned DEN_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

   // Bits needed to hold the values 0..num_w, i.e. clog2(num_w+1).
   function automatic int unsigned cnt_width(input int unsigned num_w);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < (64'(num_w) + 64'd1)) w++;
      return w;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract the divisor.
`timescale 1ns/1ps
module div_step
   import divider_pkg::*;
#(
   parameter int unsigned DEN_W = DEN_W_DEF
) (
   input  logic [DEN_W-1:0] r,
   input  logic             bit_in,
   input  logic [DEN_W-1:0] d,
   output logic [DEN_W-1:0] r_next,
   output logic             q_bit
);

   logic [DEN_W:0] p;

   assign p     = {r, bit_in};
   assign q_bit = (p >= {1'b0, d});
   // When the subtraction is taken the true difference is < d, so DEN_W-bit modular arithmetic is exact.
   assign r_next = q_bit ? (p[DEN_W-1:0] - d) : p[DEN_W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
`timescale 1ns/1ps
module seq_divider
   import divider_pkg::*;
#(
   parameter int unsigned NUM_W = NUM_W_DEF,
   parameter int unsigned DEN_W = DEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] numerator,
   input  logic [DEN_W-1:0] denominator,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] quotient,
   output logic [DEN_W-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = cnt_width(NUM_W);

   state_t           state, state_nxt;
   logic [NUM_W-1:0] nq_sh;
   logic [DEN_W-1:0] d_reg;
   logic [DEN_W-1:0] r_reg;
   logic [CNT_W-1:0] cnt;
   logic [DEN_W-1:0] r_next;
   logic             q_bit;
   logic             last_step;

   assign last_step = (cnt == CNT_W'(1));

   div_step #(.DEN_W(DEN_W)) u_step (
      .r      (r_reg),
      .bit_in (nq_sh[NUM_W-1]),
      .d      (d_reg),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (denominator == '0) ? FIN : CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (last_step) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Numerator bits leave at the MSB while quotient bits enter at the LSB of the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         nq_sh       <= '0;
         d_reg       <= '0;
         r_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  nq_sh <= numerator;
                  d_reg <= denominator;
                  r_reg <= '0;
                  cnt   <= CNT_W'(NUM_W);
                  if (denominator == '0) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_reg <= r_next;
               nq_sh <= {nq_sh[NUM_W-2:0], q_bit};
               cnt   <= cnt - CNT_W'(1);
               if (last_step) begin
                  quotient    <= {nq_sh[NUM_W-2:0], q_bit};
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
